record_byte_framer: RTL and testbench

//  Drains tagger records from the record FIFO (non-show-ahead, rdreq/rdempty/q) and serialises each

---
 rtl/record_byte_framer.sv | 156 +++++++++++++++
 tb/tb_record_byte_framer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/record_byte_framer.sv
// Drains words from a non-show-ahead record FIFO and serialises each one into a byte frame:
// SYNC, data bytes MSB-first, then an optional XOR checksum, for a byte-wide UART transmitter.
module record_byte_framer #(
  parameter int unsigned DATA_WIDTH_BYTES = 18,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter bit          CHECKSUM_EN      = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_rdreq,
  input  logic [8*DATA_WIDTH_BYTES-1:0] i_fifo_q,
  output logic [7:0]                    o_tx_byte,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_frame_done,
  output logic                          o_busy,
  output logic [15:0]                   o_frame_count
);

  localparam int unsigned     WordW  = 8 * DATA_WIDTH_BYTES;
  localparam int unsigned     IdxW   = (DATA_WIDTH_BYTES > 1) ? $clog2(DATA_WIDTH_BYTES) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(DATA_WIDTH_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSync,
    StData,
    StCsum
  } state_e;

  state_e           r_state, w_state_d;
  logic [WordW-1:0] r_word, w_word_d, w_word_shl;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [7:0]       r_csum, w_csum_d;
  logic [7:0]       r_tx_byte, w_tx_byte_d;
  logic             r_tx_valid, w_tx_valid_d;
  logic             r_rdreq, w_rdreq_d;
  logic             r_done, w_done_d;
  logic             r_busy, w_busy_d;
  logic [15:0]      r_frame_count, w_frame_count_d;
  logic             w_xfer;

  assign w_xfer     = r_tx_valid && i_tx_ready;
  // The word shifts left as bytes go out, so the current byte is always the top one.
  assign w_word_shl = r_word << 8;

  always_comb begin
    w_state_d       = r_state;
    w_word_d        = r_word;
    w_idx_d         = r_idx;
    w_csum_d        = r_csum;
    w_tx_byte_d     = r_tx_byte;
    w_tx_valid_d    = r_tx_valid;
    w_rdreq_d       = 1'b0;
    w_done_d        = 1'b0;
    w_frame_count_d = r_frame_count;

    unique case (r_state)
      StIdle: begin
        if (i_enable && !i_fifo_empty) begin
          w_state_d = StRead;
          w_rdreq_d = 1'b1;
        end
      end
      StRead: begin
        w_state_d = StLatch;
      end
      StLatch: begin
        w_word_d     = i_fifo_q;
        w_csum_d     = 8'h00;
        w_idx_d      = IdxTop;
        w_tx_byte_d  = SYNC_BYTE;
        w_tx_valid_d = 1'b1;
        w_state_d    = StSync;
      end
      StSync: begin
        if (w_xfer) begin
          w_tx_byte_d = r_word[WordW-1 -: 8];
          w_state_d   = StData;
        end
      end
      StData: begin
        if (w_xfer) begin
          w_csum_d = r_csum ^ r_tx_byte;
          if (r_idx == '0) begin
            if (CHECKSUM_EN) begin
              w_tx_byte_d = w_csum_d;
              w_state_d   = StCsum;
            end else begin
              w_tx_valid_d    = 1'b0;
              w_done_d        = 1'b1;
              w_frame_count_d = r_frame_count + 16'd1;
              w_state_d       = StIdle;
            end
          end else begin
            w_idx_d     = r_idx - 1'b1;
            w_word_d    = w_word_shl;
            w_tx_byte_d = w_word_shl[WordW-1 -: 8];
          end
        end
      end
      StCsum: begin
        if (w_xfer) begin
          w_tx_valid_d    = 1'b0;
          w_done_d        = 1'b1;
          w_frame_count_d = r_frame_count + 16'd1;
          w_state_d       = StIdle;
        end
      end
      default: begin
        w_tx_valid_d = 1'b0;
        w_state_d    = StIdle;
      end
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_word        <= '0;
      r_idx         <= '0;
      r_csum        <= 8'h00;
      r_tx_byte     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_rdreq       <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      r_state       <= w_state_d;
      r_word        <= w_word_d;
      r_idx         <= w_idx_d;
      r_csum        <= w_csum_d;
      r_tx_byte     <= w_tx_byte_d;
      r_tx_valid    <= w_tx_valid_d;
      r_rdreq       <= w_rdreq_d;
      r_done        <= w_done_d;
      r_busy        <= w_busy_d;
      r_frame_count <= w_frame_count_d;
    end
  end

  assign o_fifo_rdreq  = r_rdreq;
  assign o_tx_byte     = r_tx_byte;
  assign o_tx_valid    = r_tx_valid;
  assign o_frame_done  = r_done;
  assign o_busy        = r_busy;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_record_byte_framer.sv
// Scoreboard bench for record_byte_framer: one instance with checksum, one without (wrap test).
module tb_record_byte_framer;

  localparam int unsigned DWB     = 18;
  localparam int unsigned W       = 8 * DWB;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int          FRAME_A = 1 + DWB + 1;
  localparam int          FRAME_B = 1 + DWB;

  logic clk = 1'b0;
  logic rst_n, enable, tx_ready;
  always #5 clk = ~clk;

  logic         a_empty = 1'b1, a_rdreq, a_valid, a_done, a_busy;
  logic [W-1:0] a_q = '0;
  logic [7:0]   a_byte;
  logic [15:0]  a_count;
  logic         b_empty = 1'b1, b_rdreq, b_valid, b_done, b_busy;
  logic [W-1:0] b_q = '0;
  logic [7:0]   b_byte;
  logic [15:0]  b_count;

  record_byte_framer #(.DATA_WIDTH_BYTES(DWB), .SYNC_BYTE(SYNC), .CHECKSUM_EN(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_fifo_empty(a_empty),
    .o_fifo_rdreq(a_rdreq), .i_fifo_q(a_q), .o_tx_byte(a_byte), .o_tx_valid(a_valid),
    .i_tx_ready(tx_ready), .o_frame_done(a_done), .o_busy(a_busy), .o_frame_count(a_count)
  );

  record_byte_framer #(.DATA_WIDTH_BYTES(DWB), .SYNC_BYTE(SYNC), .CHECKSUM_EN(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_fifo_empty(b_empty),
    .o_fifo_rdreq(b_rdreq), .i_fifo_q(b_q), .o_tx_byte(b_byte), .o_tx_valid(b_valid),
    .i_tx_ready(tx_ready), .o_frame_done(b_done), .o_busy(b_busy), .o_frame_count(b_count)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Non-show-ahead FIFO models: q updates on the edge that ends the rdreq cycle.
  logic [W-1:0] fa[$];
  logic [W-1:0] fb[$];
  always @(posedge clk) begin
    if (a_rdreq && fa.size() != 0) a_q <= fa.pop_front();
    if (b_rdreq && fb.size() != 0) b_q <= fb.pop_front();
    a_empty <= (fa.size() == 0);
    b_empty <= (fb.size() == 0);
  end

  logic [7:0] ea[$];
  logic [7:0] eb[$];

  task automatic push_a(input logic [W-1:0] w);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    fa.push_back(w);
    ea.push_back(SYNC);
    for (int i = DWB - 1; i >= 0; i--) begin
      b  = w[8*i +: 8];
      cs = cs ^ b;
      ea.push_back(b);
    end
    ea.push_back(cs);
  endtask

  task automatic push_b(input logic [W-1:0] w);
    fb.push_back(w);
    eb.push_back(SYNC);
    for (int i = DWB - 1; i >= 0; i--) eb.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < DWB; i++) w = {w[W-9:0], 8'($urandom_range(0, 255))};
    return w;
  endfunction

  // Monitor state for instance A (owned by the monitor process).
  int         a_pos = 0, a_frames = 0, a_rd_cnt = 0, a_lat_cnt = 0;
  bit         a_done_pend = 0, a_stall = 0, a_lat_arm = 0, a_prev_rd = 0;
  logic [7:0] a_stall_byte = 8'h00;
  logic [15:0] a_exp_count = 16'h0000;
  logic [7:0] a_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      ea.delete();
      a_pos = 0; a_done_pend = 0; a_stall = 0; a_lat_arm = 0; a_prev_rd = 0;
      a_exp_count = 16'h0000;
    end else begin
      if (a_stall) begin
        check("stall_byte", a_byte, a_stall_byte);
        check("stall_valid", a_valid, 1);
      end
      a_stall      = a_valid && !tx_ready;
      a_stall_byte = a_byte;

      if (a_done_pend) begin
        check("frame_done", a_done, 1);
        check("frame_count", a_count, a_exp_count);
        check("busy_at_done", a_busy, 0);
        a_done_pend = 0;
      end else if (a_done) begin
        check("spurious_done", a_done, 0);
      end

      if (a_lat_arm) begin
        a_lat_cnt++;
        if (a_valid) begin
          check("sync_latency", a_lat_cnt, 2);
          a_lat_arm = 0;
        end
      end
      if (a_rdreq) begin
        check("rdreq_while_empty", a_empty, 0);
        check("rdreq_in_frame", a_pos != 0, 0);
        check("rdreq_pulse", a_prev_rd, 0);
        a_rd_cnt++;
        a_lat_arm = 1;
        a_lat_cnt = 0;
      end
      a_prev_rd = a_rdreq;

      if (a_valid && tx_ready) begin
        check("a_sb_has_byte", ea.size() != 0, 1);
        if (ea.size() != 0) begin
          a_exp = ea.pop_front();
          check("a_byte", a_byte, a_exp);
        end
        check("busy_in_frame", a_busy, 1);
        a_pos++;
        if (a_pos == FRAME_A) begin
          a_pos = 0;
          a_done_pend = 1;
          a_exp_count = a_exp_count + 16'd1;
          a_frames++;
        end
      end
    end
  end

  int         b_pos = 0, b_frames = 0;
  bit         b_done_pend = 0;
  logic [7:0] b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      eb.delete();
      b_pos = 0; b_done_pend = 0;
    end else begin
      if (b_done_pend) begin
        check("b_frame_done", b_done, 1);
        b_done_pend = 0;
      end else if (b_done) begin
        check("b_spurious_done", b_done, 0);
      end
      if (b_valid && tx_ready) begin
        check("b_sb_has_byte", eb.size() != 0, 1);
        if (eb.size() != 0) begin
          b_exp = eb.pop_front();
          check("b_byte", b_byte, b_exp);
        end
        b_pos++;
        if (b_pos == FRAME_B) begin
          b_pos = 0;
          b_done_pend = 1;
          b_frames++;
        end
      end
    end
  end

  task automatic wait_frames(input bit which, input int target, input bit rnd);
    int got;
    got = which ? b_frames : a_frames;
    for (int i = 0; i < 3000 && got < target; i++) begin
      @(posedge clk);
      #1;
      if (rnd) tx_ready = ($urandom_range(0, 9) < 3);
      got = which ? b_frames : a_frames;
    end
    check("wait_frames_timeout", got >= target, 1);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int target);
    for (int i = 0; i < 200 && a_pos < target; i++) begin
      @(posedge clk);
      #1;
    end
    check("wait_pos_timeout", a_pos >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, a_rdreq, 0);
    check({tag, "_valid"}, a_valid, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_byte"}, a_byte, 0);
    check({tag, "_count"}, a_count, 0);
  endtask

  logic [W-1:0] word1;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    tx_ready = 1'b1;
    word1    = '0;
    for (int i = 0; i < DWB; i++) word1 = {word1[W-9:0], 8'(i)};
    #2;
    check_reset_outputs("reset");
    check("reset_b_count", b_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;

    // Single frame, ready always high.
    push_a(word1);
    wait_frames(1'b0, 1, 1'b0);
    check("t1_rdreq_count", a_rd_cnt, 1);
    check("t1_frame_count", a_count, 1);

    // Same word with a mostly-stalled UART.
    push_a(word1);
    wait_frames(1'b0, 2, 1'b1);
    check("t2_rdreq_count", a_rd_cnt, 2);

    // Three queued words back-to-back.
    for (int i = 0; i < 3; i++) push_a(rand_word());
    wait_frames(1'b0, 5, 1'b0);
    check("t3_rdreq_count", a_rd_cnt, 5);
    check("t3_frame_count", a_count, 5);

    // enable dropped at data byte 5: frame completes, next word waits.
    push_a(rand_word());
    push_a(rand_word());
    wait_pos(6);
    enable = 1'b0;
    wait_frames(1'b0, 6, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("t4_no_rdreq_disabled", a_rd_cnt, 6);
    check("t4_idle_busy", a_busy, 0);
    enable = 1'b1;
    wait_frames(1'b0, 7, 1'b0);
    check("t4_rdreq_resumed", a_rd_cnt, 7);

    // Asynchronous reset mid-frame at data byte 9.
    push_a(rand_word());
    wait_pos(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_resume", a_valid, 0);
    push_a(rand_word());
    wait_frames(1'b0, 8, 1'b0);
    check("t5_rdreq_count", a_rd_cnt, 9);
    check("t5_frame_count", a_count, 1);

    // No-checksum instance: 19-byte frames and counter wrap.
    push_b(rand_word());
    wait_frames(1'b1, 1, 1'b0);
    check("t6_count_first", b_count, 1);
    force dut_b.r_frame_count = 16'hFFFE;
    #1;
    release dut_b.r_frame_count;
    push_b(rand_word());
    wait_frames(1'b1, 2, 1'b0);
    check("t6_count_ffff", b_count, 16'hFFFF);
    push_b(rand_word());
    wait_frames(1'b1, 3, 1'b0);
    check("t6_count_wrap", b_count, 16'h0000);
    check("t6_a_untouched", a_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
